// File: rtl/uart_frame_responder.sv
// Modbus-style request/response responder sitting between a byte-level UART receiver and transmitter.
// Parses 4-byte requests (ADDR, CMD, CRC16), then answers read requests with a latched payload.
`timescale 1ns/1ps
module uart_frame_responder #(
  parameter int unsigned BYTES       = 4,
  parameter logic [7:0]  ADDRESS     = 8'h01,
  parameter int unsigned TURNAROUND  = 16,
  parameter int unsigned GAP_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             baud_clock,
  input  logic [7:0]       rx_data_i,
  input  logic             new_rx_data_i,
  output logic [7:0]       tx_data_o,
  output logic             new_tx_data_o,
  input  logic             tx_busy_i,
  input  logic [BYTES*8-1:0] data_i,
  output logic             busy_o,
  output logic [7:0]       req_ok_cnt_o,
  output logic [7:0]       crc_err_cnt_o
);

  localparam int unsigned   GW         = $clog2(GAP_TIMEOUT + 1) + 1;
  localparam logic [GW-1:0] GAP_LIMIT  = GW'(GAP_TIMEOUT);
  localparam logic [15:0]   TURN_LIMIT = 16'(TURNAROUND);
  localparam logic [7:0]    LAST_DATA  = 8'(BYTES - 1);
  localparam logic [7:0]    CMD_READ   = 8'h01;

  typedef enum logic [2:0] {
    P_IDLE, P_GET_CMD, P_GET_CRC_L, P_GET_CRC_H, P_CHECK
  } pstate_t;

  typedef enum logic [2:0] {
    R_IDLE, R_WAIT, R_SEND_HDR, R_SEND_DATA, R_SEND_CRC, R_DONE
  } rstate_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  pstate_t       pstate, pnext;
  rstate_t       rstate, rnext;
  logic [7:0]    addr_q, cmd_q;
  logic [15:0]   rx_crc;
  logic [GW-1:0] gap_cnt;
  logic          gap_timeout, start_frame, accept, crc_err_event;

  logic [15:0]        turn_cnt;
  logic [7:0]         idx;
  logic [7:0]         resp_cmd;
  logic               is_read;
  logic [BYTES*8-1:0] payload;
  logic [15:0]        tx_crc;
  logic [7:0]         tx_byte;
  logic               send_state, fire, last;

  // ---------------- request parser ----------------
  always_comb begin
    gap_timeout = (pstate inside {P_GET_CMD, P_GET_CRC_L, P_GET_CRC_H}) && (gap_cnt >= GAP_LIMIT);
    // A byte landing on a timeout (or right after CHECK) opens a fresh frame rather than being lost.
    start_frame = new_rx_data_i && (pstate == P_IDLE || pstate == P_CHECK || gap_timeout);
    pnext = pstate;
    if (start_frame) begin
      pnext = P_GET_CMD;
    end else if (gap_timeout) begin
      pnext = P_IDLE;
    end else begin
      case (pstate)
        P_GET_CMD:   if (new_rx_data_i) pnext = P_GET_CRC_L;
        P_GET_CRC_L: if (new_rx_data_i) pnext = P_GET_CRC_H;
        P_GET_CRC_H: if (new_rx_data_i) pnext = P_CHECK;
        P_CHECK:     pnext = P_IDLE;
        default:     pnext = pstate;
      endcase
    end
  end

  always_comb begin
    accept        = (pstate == P_CHECK) && (rx_crc == '0) && (addr_q == ADDRESS) && (rstate == R_IDLE);
    crc_err_event = (pstate == P_CHECK) && (rx_crc != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pstate <= P_IDLE;
    else       pstate <= pnext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q        <= '0;
      cmd_q         <= '0;
      rx_crc        <= '0;
      gap_cnt       <= '0;
      req_ok_cnt_o  <= '0;
      crc_err_cnt_o <= '0;
    end else begin
      if (start_frame) begin
        addr_q <= rx_data_i;
        rx_crc <= crc16_byte('1, rx_data_i);
      end else if (new_rx_data_i && (pstate inside {P_GET_CMD, P_GET_CRC_L, P_GET_CRC_H})) begin
        rx_crc <= crc16_byte(rx_crc, rx_data_i);
        if (pstate == P_GET_CMD) cmd_q <= rx_data_i;
      end

      if (new_rx_data_i || pstate == P_IDLE || gap_timeout) gap_cnt <= '0;
      else if (baud_clock)                                  gap_cnt <= gap_cnt + 1'b1;

      if (accept) req_ok_cnt_o <= req_ok_cnt_o + 8'd1;
      if (crc_err_event && crc_err_cnt_o != '1) crc_err_cnt_o <= crc_err_cnt_o + 8'd1;
    end
  end

  // ---------------- response sequencer ----------------
  always_comb begin
    send_state = rstate inside {R_SEND_HDR, R_SEND_DATA, R_SEND_CRC};
    // new_tx_data_o is registered, so gating on it spaces pulses and holds tx_data_o for two cycles.
    fire       = send_state && !tx_busy_i && !new_tx_data_o;
  end

  always_comb begin
    rnext   = rstate;
    tx_byte = '0;
    last    = 1'b0;
    case (rstate)
      R_IDLE: if (accept) rnext = R_WAIT;
      R_WAIT: if (turn_cnt >= TURN_LIMIT) rnext = R_SEND_HDR;
      R_SEND_HDR: begin
        tx_byte = (idx == 8'd0) ? ADDRESS : resp_cmd;
        last    = (idx == 8'd1);
        if (fire && last) rnext = is_read ? R_SEND_DATA : R_SEND_CRC;
      end
      R_SEND_DATA: begin
        tx_byte = payload[7:0];
        last    = (idx == LAST_DATA);
        if (fire && last) rnext = R_SEND_CRC;
      end
      R_SEND_CRC: begin
        tx_byte = (idx == 8'd0) ? tx_crc[7:0] : tx_crc[15:8];
        last    = (idx == 8'd1);
        if (fire && last) rnext = R_DONE;
      end
      R_DONE:  rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rstate <= R_IDLE;
    else       rstate <= rnext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      turn_cnt      <= '0;
      idx           <= '0;
      resp_cmd      <= '0;
      is_read       <= 1'b0;
      payload       <= '0;
      tx_crc        <= '0;
      tx_data_o     <= '0;
      new_tx_data_o <= 1'b0;
    end else begin
      new_tx_data_o <= fire;
      if (accept) begin
        payload  <= data_i;
        is_read  <= (cmd_q == CMD_READ);
        resp_cmd <= (cmd_q == CMD_READ) ? cmd_q : (cmd_q | 8'h80);
        tx_crc   <= '1;
        idx      <= '0;
        turn_cnt <= '0;
      end
      if (rstate == R_WAIT && baud_clock && turn_cnt < TURN_LIMIT) turn_cnt <= turn_cnt + 16'd1;
      if (fire) begin
        tx_data_o <= tx_byte;
        idx       <= last ? 8'd0 : idx + 8'd1;
        if (rstate != R_SEND_CRC)  tx_crc  <= crc16_byte(tx_crc, tx_byte);
        if (rstate == R_SEND_DATA) payload <= payload >> 8;
      end
    end
  end

  assign busy_o = (rstate != R_IDLE) || accept;

endmodule
